fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the write port of one synchronous FIFO among N pixel sources.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit pointer, so clamp the width at 1.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin find-first.
// Scans from ptr+1 upward, wrapping at N-1, and returns the first requester that is set.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  // N need not be a power of two, so wrap by comparing against N-1.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = ptr;
    for (int k = 0; k < N; k++) begin
      cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N sources, with bursts of up to BURST beats.
// Defining ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_wr_data,
  output logic [N-1:0]       grant
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int PW = ptr_width(N);
  localparam int CW = cnt_width(BURST);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [PW-1:0] last_ptr_q, last_ptr_d;

  logic [PW-1:0] g_idx;
  logic          g_valid;
  logic          xfer;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (last_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) g_idx = PW'(i);
    end
  end

  assign g_valid      = req_valid[g_idx];
  assign xfer         = (state_q == ST_GRANT) && g_valid && !fifo_full;
  assign fifo_wr_en   = xfer;
  assign req_ready    = grant_q & {N{xfer}};
  assign fifo_wr_data = xfer ? req_data[int'(g_idx)*WIDTH +: WIDTH] : '0;
  assign grant        = grant_q;

  // A stall (valid while full) falls through both branches and holds grant and beat count.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          grant_d    = pick_onehot;
          last_ptr_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!g_valid) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CW'(BURST - 1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      last_ptr_q <= PW'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_GRANT) && g_valid && fifo_full && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural depth-8 FIFO occupancy model,
// per-requester beat sources and a scoreboard of expected write data.
module tb_fifo_wr_arbiter;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic [N-1:0]   grant;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbq[$];
  logic [N-1:0] gq[$];
  logic [N-1:0] prev_grant;
  int           fifo_count;
  logic         pop;
  int           left[N];
  logic [7:0]   base[N];
  logic [7:0]   beat[N];
  int           n;

  fifo_wr_arbiter #(
    .N     (N),
    .WIDTH (W),
    .BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives DUT inputs from the source and FIFO models.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (left[i] > 0);
      req_data[i*W +: W] = base[i] + beat[i];
    end
    fifo_full = (fifo_count >= DEPTH);
  endtask

  task automatic pushRange(input logic [7:0] start, input int cnt);
    for (int k = 0; k < cnt; k++) sbq.push_back(start + 8'(k));
  endtask

  // One clock: sample at the negedge, cross the posedge, then advance the models.
  task automatic tick();
    logic [N-1:0] rdy;
    logic         wr;
    logic [7:0]   wd;
    logic         dec;
    rdy = req_ready;
    wr  = fifo_wr_en;
    wd  = fifo_wr_data;
    if (!rst) begin
      checkOutput("inv_onehot0", 32'($onehot0(grant)), 32'd1);
      checkOutput("inv_no_wr_when_full", 32'((wr === 1'b1) && fifo_full), 32'd0);
      if (grant !== prev_grant && grant !== '0) gq.push_back(grant);
      prev_grant = grant;
    end
    if (wr === 1'b1) begin
      if (sbq.size() == 0) checkOutput("sb_extra_write", 32'(sbq.size() != 0), 32'd1);
      else                 checkOutput("sb_data", {24'd0, wd}, {24'd0, sbq.pop_front()});
    end
    @(posedge clk);
    #1;
    dec = pop && (fifo_count > 0);
    if (rst) fifo_count = 0;
    else     fifo_count = fifo_count + ((wr === 1'b1) ? 1 : 0) - (dec ? 1 : 0);
    for (int i = 0; i < N; i++) begin
      if (rdy[i] === 1'b1 && left[i] > 0) begin
        left[i]--;
        beat[i]++;
      end
    end
    applyStimulus();
    @(negedge clk);
  endtask

  task automatic drainSb(input int budget, output int cnt);
    cnt = 0;
    while (sbq.size() != 0 && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    pop = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      base[i] = 8'h00;
      beat[i] = 8'h00;
    end
    fifo_count = 0;
    prev_grant = '0;
    applyStimulus();
    tick();
    tick();
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'd0);
`ifdef ARB_STALL_CNT_EN
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    // Single requester, full burst, then back to idle.
    resetDut();
    base[0] = 8'h10; left[0] = 4;
    pushRange(8'h10, 4);
    applyStimulus();
    tick();
    checkOutput("t1_grant", 32'(grant), 32'b001);
    checkOutput("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    checkOutput("t1_ready", 32'(req_ready), 32'b001);
    drainSb(20, n);
    checkOutput("t1_cycles", 32'(n), 32'd4);
    checkOutput("t1_idle_grant", 32'(grant), 32'd0);
    checkOutput("t1_fifo_words", 32'(fifo_count), 32'd4);

    // All three valid: rotation 0,1,2,0 with one idle arbitration cycle per burst.
    resetDut();
    pop = 1'b1;
    gq.delete();
    base[0] = 8'h20; left[0] = 8;
    base[1] = 8'h40; left[1] = 4;
    base[2] = 8'h60; left[2] = 4;
    pushRange(8'h20, 4);
    pushRange(8'h40, 4);
    pushRange(8'h60, 4);
    pushRange(8'h24, 4);
    applyStimulus();
    drainSb(60, n);
    checkOutput("t2_cycles", 32'(n), 32'd20);
    checkOutput("t2_grant_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      checkOutput("t2_seq0", 32'(gq[0]), 32'b001);
      checkOutput("t2_seq1", 32'(gq[1]), 32'b010);
      checkOutput("t2_seq2", 32'(gq[2]), 32'b100);
      checkOutput("t2_seq3", 32'(gq[3]), 32'b001);
    end
    pop = 1'b0;

    // FIFO fills after one beat; the grant holds until space returns.
    resetDut();
    fifo_count = 7;
    base[1] = 8'h50; left[1] = 4;
    pushRange(8'h50, 4);
    applyStimulus();
    tick();
    checkOutput("t3_grant", 32'(grant), 32'b010);
    checkOutput("t3_wr_en", 32'(fifo_wr_en), 32'd1);
    tick();
    checkOutput("t3_full", 32'(fifo_full), 32'd1);
    checkOutput("t3_stall_wr", 32'(fifo_wr_en), 32'd0);
    checkOutput("t3_stall_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    checkOutput("t3_hold_grant", 32'(grant), 32'b010);
    pop = 1'b1;
    drainSb(20, n);
    checkOutput("t3_resume_cycles", 32'(n), 32'd4);
    checkOutput("t3_end_grant", 32'(grant), 32'd0);
    pop = 1'b0;

    // Requester 2 drops valid after two beats.
    resetDut();
    base[2] = 8'h70; left[2] = 2;
    pushRange(8'h70, 2);
    applyStimulus();
    tick();
    checkOutput("t4_grant", 32'(grant), 32'b100);
    tick();
    tick();
    checkOutput("t4_drop_wr", 32'(fifo_wr_en), 32'd0);
    tick();
    checkOutput("t4_idle_grant", 32'(grant), 32'd0);
    checkOutput("t4_fifo_words", 32'(fifo_count), 32'd2);
    checkOutput("t4_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset during beat 2; next grant must go to requester 0.
    resetDut();
    base[1] = 8'h90; left[1] = 4;
    pushRange(8'h90, 2);
    applyStimulus();
    tick();
    tick();
    checkOutput("t5_beat2_wr", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_grant", 32'(grant), 32'd0);
    checkOutput("t5_rst_wr", 32'(fifo_wr_en), 32'd0);
    rst = 1'b0;
    base[0] = 8'h80; left[0] = 4;
    pushRange(8'h80, 4);
    pushRange(8'h92, 2);
    applyStimulus();
    tick();
    checkOutput("t5_next_grant", 32'(grant), 32'b001);
    drainSb(30, n);
    checkOutput("t5_cycles", 32'(n), 32'd7);
    tick();
    checkOutput("t5_end_grant", 32'(grant), 32'd0);

    // Full for five granted cycles with valid held.
    resetDut();
    fifo_count = DEPTH;
    base[0] = 8'hA0; left[0] = 4;
    pushRange(8'hA0, 4);
    applyStimulus();
    tick();
    checkOutput("t6_grant", 32'(grant), 32'b001);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("t6_hold_grant", 32'(grant), 32'b001);
    checkOutput("t6_stall_wr", 32'(fifo_wr_en), 32'd0);
`ifdef ARB_STALL_CNT_EN
    checkOutput("t6_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    pop = 1'b1;
    drainSb(20, n);
    checkOutput("t6_resume_cycles", 32'(n), 32'd5);
    checkOutput("t6_end_grant", 32'(grant), 32'd0);
    pop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
